alu_serial: RTL and testbench

ALU_SERIAL -- requirements
Module: alu_serial

---
 rtl/alu_serial.sv | 177 +++++++++++++++++
 tb/tb_alu_serial.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// ---------------------------------------------------------------------------
// alu_serial -- bit-serial 2-operand ALU (AND / OR / ADD / SUB), LSB first.
//
// A single one-bit ALU slice (alu1b) processes one bit per clock. Operands
// sit in right-shifting registers whose LSBs feed the slice; the slice carry
// is held in a flip-flop between bits. A WIDTH-bit operation occupies RUN
// for WIDTH cycles, then DONE for one cycle, then returns to IDLE.
//
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   request a new operation (sampled only in IDLE)
//   op      in   2'b00 AND, 2'b01 OR, 2'b10 ADD, 2'b11 SUB (a-b)
//   a, b    in   WIDTH-bit operands, captured when start is accepted
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse, result and flags valid
//   result  out  WIDTH-bit result, held until the next operation completes
//   cout    out  final carry (ADD/SUB), 0 for logic ops
//   zero    out  result == 0
//   ovf     out  signed overflow (ADD/SUB), 0 for logic ops
// ---------------------------------------------------------------------------

// One-bit ALU slice.
//   s = 00 AND, 01 OR, 10 full-adder sum, 11 constant 0 (unused here)
module alu1b (
  input  logic       a,
  input  logic       b,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic       cin,
  input  logic [1:0] s,
  output logic       x,
  output logic       cout
);
  logic a_e;
  logic b_e;

  always_comb begin
    a_e  = a ^ ainvert;
    b_e  = b ^ binvert;
    cout = (a_e & b_e) | (a_e & cin) | (b_e & cin);
    x    = 1'b0;
    case (s)
      2'b00:   x = a_e & b_e;
      2'b01:   x = a_e | b_e;
      2'b10:   x = a_e ^ b_e ^ cin;
      default: x = 1'b0;
    endcase
  end
endmodule

module alu_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Bit 0 of the partial result is never needed on its own: the final
  // result is formed from the slice output plus these upper bits.
  logic [WIDTH-1:1] acc;
  logic [1:0]       op_q;

  logic             accept;
  logic             last_bit;
  logic             is_arith;
  logic [1:0]       slice_s;
  logic             slice_binv;
  logic             slice_x;
  logic             slice_cout;
  logic [WIDTH-1:0] res_next;
  logic             cin_msb;

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == RUN) && (cnt_q == LAST);
  assign is_arith = op_q[1];

  // SUB reuses the adder path with b inverted and carry-in preset to 1.
  assign slice_s    = (op_q == OP_SUB) ? 2'b10 : op_q;
  assign slice_binv = (op_q == OP_SUB);

  alu1b u_slice (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .ainvert (1'b0),
    .binvert (slice_binv),
    .cin     (carry_q),
    .s       (slice_s),
    .x       (slice_x),
    .cout    (slice_cout)
  );

  assign res_next = {slice_x, acc[WIDTH-1:1]};
  // Carry entering the MSB slice; overflow is its XOR with the carry out.
  assign cin_msb  = carry_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and visible outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        carry_q <= (op == OP_SUB);
      end else if (state_q == RUN) begin
        cnt_q   <= cnt_q + 1'b1;
        carry_q <= slice_cout;
      end
      if (last_bit) begin
        result <= res_next;
        zero   <= (res_next == '0);
        cout   <= is_arith & slice_cout;
        ovf    <= is_arith & (cin_msb ^ slice_cout);
      end
    end
  end

  // Operand and partial-result shifters
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
      op_q <= op;
    end else if (state_q == RUN) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      acc  <= res_next[WIDTH-1:1];
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_alu_serial.sv
module tb_alu_serial;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
  logic         ovf;

  int   n_checks;
  int   n_fail;
  int   dcount;
  exp_t sb_q[$];
  logic [W-1:0] last_res;

  alu_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t     e;
    logic [W:0] s;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      2'b00: e.res = x & y;
      2'b01: e.res = x | y;
      2'b10: begin
        s     = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
      default: begin
        s     = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
      end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Scoreboard: every done pulse consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      dcount++;
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("cout", 32'(cout), 32'(e.c));
        check("zero", 32'(zero), 32'(e.z));
        check("ovf", 32'(ovf), 32'(e.v));
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int   k;
    exp_t e;
    wait_idle();
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    e = model(o, x, y);
    sb_q.push_back(e);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 3) begin
        a = W'($urandom);
        check("hold_result", 32'(result), 32'(last_res));
      end
    end
    // done occupies the 9th clock cycle after the accepting edge
    check("latency", 32'(k), 32'(W));
    last_res = e.res;
  endtask

  initial begin
    int   k;
    int   bcnt;
    int   d0;
    exp_t e;
    logic [1:0]   b2b_op[4];
    logic [W-1:0] b2b_a[4];
    logic [W-1:0] b2b_b[4];

    n_checks = 0;
    n_fail   = 0;
    dcount   = 0;
    last_res = '0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(2'b10, 8'h7F, 8'h01);
    run_op(2'b11, 8'h05, 8'h05);
    run_op(2'b11, 8'h03, 8'h05);
    run_op(2'b00, 8'hF0, 8'h3C);
    run_op(2'b01, 8'hF0, 8'h3C);
    run_op(2'b11, 8'h80, 8'h01);
    run_op(2'b10, 8'h80, 8'h80);

    // Random mix
    for (int i = 0; i < 6; i++) begin
      run_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    end

    // Result holds through IDLE
    repeat (3) @(negedge clk);
    check("idle_hold", 32'(result), 32'(last_res));

    // Start pulsed during RUN is ignored
    wait_idle();
    d0    = dcount;
    start = 1'b1;
    op    = 2'b10;
    a     = 8'hFF;
    b     = 8'h01;
    @(posedge clk);
    sb_q.push_back(model(2'b10, 8'hFF, 8'h01));
    #1;
    start = 1'b0;
    bcnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (i == 2) begin
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h01;
      end else begin
        start = 1'b0;
      end
    end
    check("busy_cycles", 32'(bcnt), 32'd9);
    check("single_done", 32'(dcount - d0), 32'd1);
    last_res = 8'h00;

    // Reset in the 4th RUN cycle aborts the operation
    wait_idle();
    d0    = dcount;
    start = 1'b1;
    op    = 2'b10;
    a     = 8'h12;
    b     = 8'h34;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_done", 32'(dcount - d0), 32'd0);
    last_res = '0;
    run_op(2'b10, 8'h12, 8'h34);

    // Back-to-back with start held high
    b2b_op = '{2'b10, 2'b11, 2'b00, 2'b01};
    b2b_a  = '{8'h11, 8'h40, 8'hAA, 8'h0F};
    b2b_b  = '{8'h22, 8'h41, 8'h5A, 8'hF0};
    wait_idle();
    start = 1'b1;
    op    = b2b_op[0];
    a     = b2b_a[0];
    b     = b2b_b[0];
    @(posedge clk);
    sb_q.push_back(model(b2b_op[0], b2b_a[0], b2b_b[0]));
    for (int i = 1; i < 4; i++) begin
      #1;
      op = b2b_op[i];
      a  = b2b_a[i];
      b  = b2b_b[i];
      wait_done(k);
      check("b2b_latency", 32'(k), 32'(W));
      // DONE then IDLE; the second edge accepts the next operation
      @(posedge clk);
      @(posedge clk);
      sb_q.push_back(model(b2b_op[i], b2b_a[i], b2b_b[i]));
    end
    #1;
    start = 1'b0;
    wait_done(k);
    check("b2b_latency", 32'(k), 32'(W));
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
